ai_cmd_dispatcher: RTL

- Initiator side of the AI-unit start/busy/done handshake; sits between the RISC-V execute stage and the AI unit controller.
- Buffers AI commands from the pipeline in a small FIFO and issues them one at a time as single-cycle start pulses.
- Holds each command stable until the unit reports done, supervises each command with a timeout, and counts completions.

---
 rtl/ai_ctrl_pkg.sv | 14 +
 rtl/ai_cmd_dispatcher_if.sv | 33 +++
 rtl/ai_cmd_fifo.sv | 72 +++++++
 rtl/ai_cmd_dispatcher.sv | 125 ++++++++++++
 4 files changed

// File: rtl/ai_ctrl_pkg.sv
// Shared types and constants for the AI command dispatcher: FSM encoding and
// the AI unit's handshake timing used by models of the unit.
package ai_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } ai_state_e;

  // Cycles the AI unit reports busy before pulsing done.
  localparam int unsigned AI_BUSY_TO_DONE = 1;

endpackage

// File: rtl/ai_cmd_dispatcher_if.sv
// Pipeline-side command channel plus AI-unit start/busy/done handshake.
// The dispatcher uses the master view; the pipeline/AI-unit side uses slave.
interface ai_cmd_dispatcher_if #(
  parameter int DEPTH = 4,
  parameter int CMD_W = 32,
  parameter int CNT_W = 16
);
  localparam int PEND_W = $clog2(DEPTH) + 1;

  logic              cmd_valid;
  logic [CMD_W-1:0]  cmd_data;
  logic              cmd_ready;
  logic              ai_start;
  logic [CMD_W-1:0]  ai_cmd;
  logic              ai_busy;
  logic              ai_done;
  logic              err_clr;
  logic              ai_error;
  logic [PEND_W-1:0] pending;
  logic              idle;
  logic [CNT_W-1:0]  done_count;

  modport master (
    input  cmd_valid, cmd_data, ai_busy, ai_done, err_clr,
    output cmd_ready, ai_start, ai_cmd, ai_error, pending, idle, done_count
  );

  modport slave (
    output cmd_valid, cmd_data, ai_busy, ai_done, err_clr,
    input  cmd_ready, ai_start, ai_cmd, ai_error, pending, idle, done_count
  );

endinterface

// File: rtl/ai_cmd_fifo.sv
// DEPTH x W synchronous FIFO with wrap-bit pointers; full, empty and count
// are registered so downstream flags never see a combinational path from push.
module ai_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_empty_next,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [AW:0]  r_count;
  logic         r_full;
  logic         r_empty;

  logic         w_push_ok;
  logic         w_pop_ok;
  logic [AW:0]  w_wr_ptr_next;
  logic [AW:0]  w_rd_ptr_next;
  logic [AW:0]  w_count_next;

  assign w_push_ok     = i_push & ~r_full;
  assign w_pop_ok      = i_pop & ~r_empty;
  assign w_wr_ptr_next = r_wr_ptr + (AW + 1)'(w_push_ok);
  assign w_rd_ptr_next = r_rd_ptr + (AW + 1)'(w_pop_ok);
  assign w_count_next  = w_wr_ptr_next - w_rd_ptr_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
      r_full   <= (w_count_next == (AW + 1)'(DEPTH));
      r_empty  <= (w_count_next == '0);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define
  // validity, and an unreset array maps onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  assign o_data       = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full       = r_full;
  assign o_empty      = r_empty;
  assign o_empty_next = (w_count_next == '0);
  assign o_count      = r_count;

endmodule

// File: rtl/ai_cmd_dispatcher.sv
// Queues AI commands from execute and issues them one at a time to the AI unit
// as start pulses, supervising each with a timeout and counting completions.
module ai_cmd_dispatcher
  import ai_ctrl_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CMD_W   = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  ai_cmd_dispatcher_if.master bus
);

  localparam int PEND_W = $clog2(DEPTH) + 1;
  localparam int TW     = $clog2(TIMEOUT + 1);

  ai_state_e         r_state;
  ai_state_e         w_state_next;
  logic              r_start;
  logic [CMD_W-1:0]  r_cmd;
  logic [TW-1:0]     r_tmo;
  logic [TW-1:0]     w_tmo_next;
  logic [CNT_W-1:0]  r_done_cnt;
  logic              r_error;
  logic              r_idle;

  logic              w_push;
  logic              w_pop;
  logic              w_done_hit;
  logic              w_tmo_hit;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_fifo_empty_next;
  logic [PEND_W-1:0] w_fifo_count;
  logic [CMD_W-1:0]  w_fifo_head;

  assign w_push = bus.cmd_valid & ~w_fifo_full;

  ai_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_data       (bus.cmd_data),
    .i_pop        (w_pop),
    .o_data       (w_fifo_head),
    .o_full       (w_fifo_full),
    .o_empty      (w_fifo_empty),
    .o_empty_next (w_fifo_empty_next),
    .o_count      (w_fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: every output of this block is given a default first so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_tmo_next   = r_tmo;
    w_done_hit   = 1'b0;
    w_tmo_hit    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_fifo_empty && !bus.ai_busy) begin
          w_pop        = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        w_tmo_next   = '0;
        w_state_next = WAIT;
      end
      WAIT: begin
        // Done is checked first so a completion on the final cycle still counts.
        if (bus.ai_done) begin
          w_done_hit   = 1'b1;
          w_state_next = IDLE;
        end else if (r_tmo == TW'(TIMEOUT - 1)) begin
          w_tmo_hit    = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_tmo_next = r_tmo + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start    <= 1'b0;
      r_cmd      <= '0;
      r_tmo      <= '0;
      r_done_cnt <= '0;
      r_error    <= 1'b0;
      r_idle     <= 1'b1;
    end else begin
      r_start <= w_pop;
      r_tmo   <= w_tmo_next;
      if (w_pop)      r_cmd      <= w_fifo_head;
      if (w_done_hit) r_done_cnt <= r_done_cnt + 1'b1;
      // A timeout coinciding with err_clr keeps the flag set.
      if (w_tmo_hit)        r_error <= 1'b1;
      else if (bus.err_clr) r_error <= 1'b0;
      r_idle <= w_fifo_empty_next && (w_state_next == IDLE);
    end
  end

  assign bus.cmd_ready  = ~w_fifo_full;
  assign bus.ai_start   = r_start;
  assign bus.ai_cmd     = r_cmd;
  assign bus.ai_error   = r_error;
  assign bus.pending    = w_fifo_count;
  assign bus.idle       = r_idle;
  assign bus.done_count = r_done_cnt;

endmodule
